// File: rtl/seq_detector_prog.sv
// rtl/seq_detector_prog.sv - runtime-programmable serial pattern detector with saturating match counter
module seq_detector_prog #(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               din_valid,
    input  logic               din,
    input  logic               pat_load,
    input  logic [MAX_LEN-1:0] pat_value,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    input  logic               count_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               armed,
    output logic               cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_DETECT = 2'd2
    } state_t;

    state_t               r_state;
    logic [MAX_LEN-1:0]   r_cfg_pat;
    logic [LEN_W-1:0]     r_cfg_len;
    logic                 r_cfg_ovl;
    logic [MAX_LEN-1:0]   r_hist;
    logic [LEN_W-1:0]     r_fill;
    logic                 r_match;
    logic [CNT_W-1:0]     r_count;
    logic                 r_armed;
    logic                 r_cfg_err;

    state_t               w_state;
    logic [MAX_LEN-1:0]   w_cfg_pat;
    logic [LEN_W-1:0]     w_cfg_len;
    logic                 w_cfg_ovl;
    logic [MAX_LEN-1:0]   w_hist;
    logic [LEN_W-1:0]     w_fill;
    logic                 w_match;
    logic [CNT_W-1:0]     w_count;
    logic                 w_cfg_err;

    logic [MAX_LEN-1:0]   w_mask;
    logic [MAX_LEN-1:0]   w_hist_shift;
    logic [LEN_W-1:0]     w_fill_inc;
    logic                 w_len_ok;
    logic                 w_beat;
    logic                 w_hit;

    // Compare mask: only the low cfg_len history bits take part in a match
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (int'(r_cfg_len) > i);
        end
    end

    // Beat qualification, shifted history, saturating fill and hit detection
    always_comb begin
        w_len_ok     = (pat_len != '0) && (pat_len <= LEN_W'(MAX_LEN));
        w_beat       = din_valid && !pat_load && (r_state != S_IDLE);
        w_hist_shift = {r_hist[MAX_LEN-2:0], din};
        w_fill_inc   = (r_fill < r_cfg_len) ? (r_fill + LEN_W'(1)) : r_cfg_len;
        w_hit        = w_beat && (w_fill_inc == r_cfg_len)
                       && (((w_hist_shift ^ r_cfg_pat) & w_mask) == '0);
    end

    // Next-state and next-output logic; a load pre-empts any beat on the same edge
    always_comb begin
        w_state   = r_state;
        w_cfg_pat = r_cfg_pat;
        w_cfg_len = r_cfg_len;
        w_cfg_ovl = r_cfg_ovl;
        w_hist    = r_hist;
        w_fill    = r_fill;
        w_match   = 1'b0;
        w_cfg_err = r_cfg_err;
        w_count   = r_count;

        if (pat_load) begin
            if (w_len_ok) begin
                w_cfg_pat = pat_value;
                w_cfg_len = pat_len;
                w_cfg_ovl = overlap;
                w_hist    = '0;
                w_fill    = '0;
                w_cfg_err = 1'b0;
                w_state   = S_FILL;
            end else begin
                w_cfg_err = 1'b1;
                w_state   = S_IDLE;
            end
        end else if (w_beat) begin
            w_hist  = w_hist_shift;
            w_match = w_hit;
            if (w_hit && !r_cfg_ovl) begin
                w_fill  = '0;
                w_state = S_FILL;
            end else begin
                w_fill  = w_fill_inc;
                w_state = (w_fill_inc == r_cfg_len) ? S_DETECT : S_FILL;
            end
        end

        // Clear beats a same-edge hit; otherwise count up and stick at all-ones
        if (count_clr) begin
            w_count = '0;
        end else if (w_match && (r_count != '1)) begin
            w_count = r_count + CNT_W'(1);
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_cfg_pat <= '0;
            r_cfg_len <= '0;
            r_cfg_ovl <= 1'b0;
            r_hist    <= '0;
            r_fill    <= '0;
            r_match   <= 1'b0;
            r_count   <= '0;
            r_armed   <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cfg_pat <= w_cfg_pat;
            r_cfg_len <= w_cfg_len;
            r_cfg_ovl <= w_cfg_ovl;
            r_hist    <= w_hist;
            r_fill    <= w_fill;
            r_match   <= w_match;
            r_count   <= w_count;
            r_armed   <= (w_state == S_DETECT);
            r_cfg_err <= w_cfg_err;
        end
    end

    assign match       = r_match;
    assign match_count = r_count;
    assign armed       = r_armed;
    assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_seq_detector_prog.sv
// tb/tb_seq_detector_prog.sv - self-checking bench for seq_detector_prog
module tb_seq_detector_prog;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               resetn;
    logic               din_valid;
    logic               din;
    logic               pat_load;
    logic [MAX_LEN-1:0] pat_value;
    logic [LEN_W-1:0]   pat_len;
    logic               overlap;
    logic               count_clr;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               armed;
    logic               cfg_err;

    seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .din_valid   (din_valid),
        .din         (din),
        .pat_load    (pat_load),
        .pat_value   (pat_value),
        .pat_len     (pat_len),
        .overlap     (overlap),
        .count_clr   (count_clr),
        .match       (match),
        .match_count (match_count),
        .armed       (armed),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_match = 0;
    int m0;

    // Reference model: window of bits received since the last (re)start
    bit               m_valid;
    bit               m_ovl;
    bit               m_err;
    logic [MAX_LEN-1:0] m_pat;
    int               m_len;
    bit               q[$];
    int               e_match, e_cnt, e_armed, e_err;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_ovl = 0; m_err = 0; m_pat = '0; m_len = 0;
        q.delete();
        e_match = 0; e_cnt = 0; e_armed = 0; e_err = 0;
    endtask

    task automatic model_step();
        bit hit;
        e_match = 0;
        if (pat_load) begin
            if (pat_len >= 1 && int'(pat_len) <= MAX_LEN) begin
                m_valid = 1; m_pat = pat_value; m_len = int'(pat_len);
                m_ovl = overlap; m_err = 0;
                q.delete();
            end else begin
                m_valid = 0; m_err = 1;
            end
        end else if (din_valid && m_valid) begin
            q.push_back(din);
            if (q.size() > m_len) void'(q.pop_front());
            if (q.size() == m_len) begin
                hit = 1;
                for (int k = 0; k < m_len; k++)
                    if (q[m_len-1-k] != m_pat[k]) hit = 0;
                if (hit) begin
                    e_match = 1;
                    if (!m_ovl) q.delete();
                end
            end
        end
        if (count_clr) e_cnt = 0;
        else if (e_match == 1 && e_cnt < CMAX) e_cnt++;
        e_armed = (m_valid && q.size() == m_len) ? 1 : 0;
        e_err = m_err;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("match", int'(match), e_match);
        check("match_count", int'(match_count), e_cnt);
        check("armed", int'(armed), e_armed);
        check("cfg_err", int'(cfg_err), e_err);
        if (match) n_match++;
    endtask

    task automatic beat(input bit b);
        din_valid = 1; din = b;
        tick();
        din_valid = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load(input logic [MAX_LEN-1:0] p, input int len, input bit ovl);
        pat_load = 1; pat_value = p; pat_len = LEN_W'(len); overlap = ovl;
        tick();
        pat_load = 0;
    endtask

    task automatic clear_count();
        count_clr = 1;
        tick();
        count_clr = 0;
    endtask

    initial begin
        resetn = 0; din_valid = 0; din = 0; pat_load = 0;
        pat_value = '0; pat_len = '0; overlap = 0; count_clr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_match", int'(match), 0);
        check("rst_count", int'(match_count), 0);
        check("rst_armed", int'(armed), 0);
        check("rst_cfg_err", int'(cfg_err), 0);
        resetn = 1;
        idle(2);

        // Overlapping 1011
        load(8'b1011, 4, 1);
        check("t1_armed_after_load", int'(armed), 0);
        beat(1); beat(0); beat(1);
        check("t1_b3_match", int'(match), 0);
        beat(1);
        check("t1_b4_match", int'(match), 1);
        check("t1_b4_armed", int'(armed), 1);
        beat(0); beat(1); beat(1);
        check("t1_b7_match", int'(match), 1);
        check("t1_count", int'(match_count), 2);

        // 11 overlap vs non-overlap
        clear_count();
        load(8'b11, 2, 1);
        m0 = n_match;
        beat(1); beat(1); beat(1); beat(1);
        check("t2_ovl_hits", n_match - m0, 3);
        check("t2_ovl_count", int'(match_count), 3);
        clear_count();
        load(8'b11, 2, 0);
        m0 = n_match;
        beat(1); beat(1); beat(1);
        check("t2_nov_b3_match", int'(match), 0);
        beat(1);
        check("t2_nov_b4_match", int'(match), 1);
        check("t2_nov_hits", n_match - m0, 2);
        check("t2_nov_count", int'(match_count), 2);

        // Gaps, then a load that swallows a same-edge beat
        load(8'b11, 2, 1);
        beat(1); beat(0);
        idle(5);
        beat(1);
        check("t3_b3_match", int'(match), 0);
        beat(1);
        check("t3_b4_match", int'(match), 1);
        pat_load = 1; pat_value = 8'b11; pat_len = LEN_W'(2); overlap = 1;
        din_valid = 1; din = 1;
        tick();
        pat_load = 0; din_valid = 0;
        check("t3_reload_armed", int'(armed), 0);
        check("t3_reload_match", int'(match), 0);
        beat(1);
        check("t3_first_beat_match", int'(match), 0);
        check("t3_first_beat_armed", int'(armed), 0);
        beat(1);
        check("t3_second_beat_match", int'(match), 1);

        // Invalid lengths
        load(8'b11, 0, 1);
        check("t4_len0_err", int'(cfg_err), 1);
        check("t4_len0_armed", int'(armed), 0);
        m0 = n_match;
        beat(1); beat(1); beat(1); beat(1);
        load(8'b11, MAX_LEN + 1, 1);
        check("t4_len9_err", int'(cfg_err), 1);
        beat(1); beat(1); beat(1); beat(1);
        check("t4_no_hits", n_match - m0, 0);
        load(8'b11, 2, 1);
        check("t4_valid_clears_err", int'(cfg_err), 0);

        // Length 1, saturation, clear vs hit
        clear_count();
        load(8'b1, 1, 0);
        m0 = n_match;
        for (int i = 0; i < 8; i++) beat(1);
        check("t5_hits", n_match - m0, 8);
        check("t5_sat_count", int'(match_count), 3);
        count_clr = 1;
        beat(1);
        count_clr = 0;
        check("t5_clr_count", int'(match_count), 0);
        check("t5_clr_match", int'(match), 1);
        beat(0);
        check("t5_zero_no_match", int'(match), 0);

        // Asynchronous reset in the middle of a match pulse
        load(8'b1, 1, 1);
        beat(1);
        check("t6_pre_match", int'(match), 1);
        #2 resetn = 0;
        #1;
        check("t6_rst_match", int'(match), 0);
        check("t6_rst_count", int'(match_count), 0);
        check("t6_rst_armed", int'(armed), 0);
        check("t6_rst_err", int'(cfg_err), 0);
        model_reset();
        #2 resetn = 1;
        m0 = n_match;
        beat(1); beat(1); beat(1);
        check("t6_no_hits_before_reload", n_match - m0, 0);
        load(8'b1, 1, 1);
        beat(1);
        check("t6_hit_after_reload", int'(match), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/seq_detector_prog.md
# seq_detector_prog

Runtime-programmable serial pattern detector, the parametrised successor to the team's fixed 1011 Mealy/Moore detector. It accepts one data bit per qualified beat and compares the bits against a loadable pattern of 1..MAX_LEN bits. It supports overlapping and non-overlapping detection and keeps a saturating match counter. It sits between a serial bit source with a valid strobe and control/status logic that programs the pattern and reads the count.

## Interface
- MAX_LEN, 8: maximum pattern length in bits; legal range 2..16.
- CNT_W, 8: match counter width.
- LEN_W, localparam $clog2(MAX_LEN+1): width of the length fields.
- clk  input  1  rising-edge clock.
- resetn  input  1  reset, asynchronous assert, active-low; deassertion is synchronous to clk by the system.
- din_valid  input  1  qualifies din on this edge.
- din  input  1  serial data bit.
- pat_load  input  1  latches a new configuration on this edge.
- pat_value  input  MAX_LEN  pattern; bit [pat_len-1] is the first bit received, bit [0] is the last.
- pat_len  input  LEN_W  pattern length.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- count_clr  input  1  synchronously clears match_count.
- match  output  1  one-cycle registered pulse per detection.
- match_count  output  CNT_W  saturating number of detections.
- armed  output  1  high in DETECT state.
- cfg_err  output  1  last load was rejected.

## Operation
- Internal registers: cfg_pat, cfg_len, cfg_ovl, hist[MAX_LEN-1:0], fill[LEN_W-1:0], state.
- Reset values: cfg_len=0, state=IDLE, hist=0, fill=0, match=0, match_count=0, armed=0, cfg_err=0.
- **pat_load** has top priority.
  - If pat_len is in 1..MAX_LEN, the block latches cfg_pat, cfg_len and cfg_ovl, clears hist and fill, clears cfg_err, and goes to FILL.
  - Otherwise it sets cfg_err=1 and goes to IDLE.
  - A din beat on the same edge is dropped. match=0 on that edge.
- **Beat.** A beat is din_valid=1 with pat_load=0 in state FILL or DETECT. On a beat:
  - hist <= {hist[MAX_LEN-2:0], din}.
  - fill <= min(fill+1, cfg_len).
- **Hit.** A hit occurs when, after the shift, fill == cfg_len and hist[cfg_len-1:0] == cfg_pat[cfg_len-1:0]. Bits above cfg_len are ignored.
- On a hit, match=1 for one cycle and match_count increments, saturating at 2^CNT_W-1.
- After a hit with cfg_ovl=0, fill is cleared to 0 and state goes to FILL. With cfg_ovl=1, fill stays at cfg_len.
- **States:**
  - IDLE: no valid pattern; beats are ignored.
  - FILL: fill < cfg_len.
  - DETECT: fill == cfg_len.
  - IDLE->FILL on a valid load.
  - FILL->DETECT when fill reaches cfg_len without a non-overlap hit.
  - DETECT->FILL on a non-overlap hit or a valid load.
  - Any state->IDLE on an invalid load.
- No beat (din_valid=0): hist, fill and state hold, and match=0.
- count_clr wins over a same-edge hit: match_count=0, while the match pulse is still asserted.
- cfg_len=1 is legal. Every beat equal to cfg_pat[0] is a hit in both modes.

## Timing
- Latency is one edge: match is high in the cycle after the clk edge that samples the completing bit. match_count updates on that same edge.
- Back-to-back hits on consecutive beats give match high on consecutive cycles, with no forced gap.
- armed follows state and is registered.
- cfg_err holds until the next valid load or reset.
- Asynchronous reset mid-stream immediately forces all outputs to their reset values. The block needs a new pat_load before it detects again.
- The new configuration applies to beats starting the edge after pat_load.

## Test plan
- **Overlap:** load 1011, len 4, overlap=1; stream 1,0,1,1,0,1,1 on consecutive beats -> match after beats 4 and 7; match_count=2.
- **Overlap vs non-overlap:** load 11, len 2; stream 1,1,1,1 -> overlap=1 gives 3 matches (beats 2,3,4); overlap=0 gives 2 matches (beats 2,4).
- **Gaps and reload:** stream 1,0 then din_valid low 5 cycles, then 1,1 -> match after the 4th valid beat. Then issue pat_load with din_valid=1 on the same edge -> beat dropped, fill=0, armed=0.
- **Invalid length:** pat_len=0, then pat_len=MAX_LEN+1 -> cfg_err=1, armed=0, no matches on any stream. A valid load then clears cfg_err.
- **Saturation and clear:** CNT_W=2, len 1, pattern 1, eight 1-beats -> match_count sticks at 3. count_clr together with a hit -> count 0, match=1.
- **Reset mid-operation:** pulse resetn low between clk edges mid-match -> match, match_count, armed and cfg_err are 0 immediately; no detection until reload.
